// File: rtl/tms320_host_port_bridge.sv
// TMS320C1x external port responder: maps DSP IN/OUT strobes onto host shared
// RAM over a req/ack interface, stalling the DSP and exposing RS/BIO/INT pins.
module tms320_host_port_bridge #(
    parameter int ADDR_W  = 15,
    parameter int INT_LEN = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE_R,
    input  logic [2:0]        DSP_A,
    input  logic [15:0]       DSP_DO,
    input  logic              DSP_WE_N,
    input  logic              DSP_DEN_N,
    output logic [15:0]       DSP_DI,
    output logic              DSP_WAIT,
    output logic              DSP_RS_N,
    output logic              DSP_BIO_N,
    output logic              DSP_INT_N,
    input  logic              HOST_CTRL_WR,
    input  logic [2:0]        HOST_CTRL_D,
    output logic              HOST_DONE,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_WDATA,
    input  logic [15:0]       MEM_RDATA,
    input  logic              MEM_ACK
);
    localparam int CNT_W = $clog2(INT_LEN + 1);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       rdata_q;
    logic [CNT_W-1:0]  int_cnt;
    logic              idle, wr_det, rd_det, port1, abort, int_trig;

    // Strobes only count while idle; a busy DSP is frozen and repeats them.
    assign idle     = (state == IDLE);
    assign wr_det   = CE_R & idle & ~DSP_WE_N;
    assign rd_det   = CE_R & idle & ~DSP_DEN_N;
    assign port1    = (DSP_A == 3'd1);
    assign abort    = HOST_CTRL_WR & ~HOST_CTRL_D[0] & ((state == RD) | (state == WR));
    assign int_trig = HOST_CTRL_WR & HOST_CTRL_D[2];

    // Combinational so the core freezes in the very cycle the access appears.
    assign DSP_WAIT = ~idle | (port1 & (wr_det | rd_det));

    always_comb begin
        DSP_DI = '0;
        case (DSP_A)
            3'd0:    DSP_DI = 16'(addr_q);
            3'd1:    DSP_DI = rdata_q;
            3'd2:    DSP_DI = {15'b0, HOST_DONE};
            default: DSP_DI = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            addr_q    <= '0;
            rdata_q   <= '0;
            int_cnt   <= '0;
            DSP_RS_N  <= 1'b0;
            DSP_BIO_N <= 1'b1;
            DSP_INT_N <= 1'b1;
            HOST_DONE <= 1'b0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else begin
            if (HOST_CTRL_WR) begin
                DSP_RS_N  <= HOST_CTRL_D[0];
                DSP_BIO_N <= ~HOST_CTRL_D[1];
            end

            // A retrigger reloads the counter, stretching an active pulse.
            if (int_trig) begin
                int_cnt   <= CNT_W'(INT_LEN);
                DSP_INT_N <= 1'b0;
            end else if (CE_R && int_cnt != '0) begin
                int_cnt <= int_cnt - 1'b1;
                if (int_cnt == CNT_W'(1))
                    DSP_INT_N <= 1'b1;
            end

            if (wr_det) begin
                case (DSP_A)
                    3'd0:    addr_q    <= DSP_DO[ADDR_W-1:0];
                    3'd3:    HOST_DONE <= DSP_DO[15];
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (port1 && wr_det) begin
                        state     <= WR;
                        MEM_REQ   <= 1'b1;
                        MEM_WE    <= 1'b1;
                        MEM_ADDR  <= addr_q;
                        MEM_WDATA <= DSP_DO;
                    end else if (port1 && rd_det) begin
                        state    <= RD;
                        MEM_REQ  <= 1'b1;
                        MEM_WE   <= 1'b0;
                        MEM_ADDR <= addr_q;
                    end
                end
                RD, WR: begin
                    // Host stopping the DSP drops the access without touching ADDR/RDATA.
                    if (abort) begin
                        state     <= IDLE;
                        MEM_REQ   <= 1'b0;
                        HOST_DONE <= 1'b0;
                    end else if (MEM_ACK) begin
                        state   <= FIN;
                        MEM_REQ <= 1'b0;
                        addr_q  <= addr_q + 1'b1;
                        if (state == RD)
                            rdata_q <= MEM_RDATA;
                    end
                end
                FIN: begin
                    if (CE_R)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tms320_host_port_bridge.sv
// Randomized scoreboard bench for tms320_host_port_bridge.
module tb_tms320_host_port_bridge;
    logic        CLK = 1'b0;
    logic        RST;
    logic        CE_R;
    logic [2:0]  DSP_A;
    logic [15:0] DSP_DO;
    logic        DSP_WE_N, DSP_DEN_N;
    logic [15:0] DSP_DI;
    logic        DSP_WAIT, DSP_RS_N, DSP_BIO_N, DSP_INT_N;
    logic        HOST_CTRL_WR;
    logic [2:0]  HOST_CTRL_D;
    logic        HOST_DONE, MEM_REQ, MEM_WE;
    logic [14:0] MEM_ADDR;
    logic [15:0] MEM_WDATA, MEM_RDATA;
    logic        MEM_ACK;

    tms320_host_port_bridge dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .DSP_A(DSP_A), .DSP_DO(DSP_DO),
        .DSP_WE_N(DSP_WE_N), .DSP_DEN_N(DSP_DEN_N), .DSP_DI(DSP_DI),
        .DSP_WAIT(DSP_WAIT), .DSP_RS_N(DSP_RS_N), .DSP_BIO_N(DSP_BIO_N),
        .DSP_INT_N(DSP_INT_N), .HOST_CTRL_WR(HOST_CTRL_WR), .HOST_CTRL_D(HOST_CTRL_D),
        .HOST_DONE(HOST_DONE), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic we; logic [14:0] addr; logic [15:0] wdata; } mreq_t;
    typedef struct { int kind; logic [15:0] exp; } probe_t;
    localparam int K_DI = 0, K_CTRL = 1, K_DONE = 2, K_REQ = 3, K_INT = 4, K_WAIT = 5;

    int checks = 0, failures = 0;
    mreq_t  mem_exp[$];
    probe_t probe_q[$];
    int     int_exp[$];

    // reference model state
    logic [14:0] addr_m = '0;
    logic [15:0] rdata_m = '0;
    logic        done_m = 1'b0;
    logic        bio_m = 1'b0;
    logic [15:0] ram_m[int];

    // environment knobs
    logic        hold_ack = 1'b0;
    logic        ce_all = 1'b0;
    int          force_dly = -1;
    int          stray_cnt = 0, stray_done = 0;
    logic [15:0] ram[int];

    function automatic logic [15:0] init_word(input logic [14:0] a);
        return {a[7:0], ~a[7:0]} ^ 16'h1357;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // memory responder
    initial begin
        bit active = 0;
        int dly = 0;
        MEM_ACK = 1'b0;
        MEM_RDATA = '0;
        forever begin
            @(negedge CLK);
            MEM_ACK = 1'b0;
            if (RST) active = 0;
            else if (stray_cnt != stray_done) begin
                stray_done++;
                MEM_ACK = 1'b1;
                MEM_RDATA = 16'($urandom);
            end else if (MEM_REQ && !hold_ack) begin
                if (!active) begin
                    active = 1;
                    dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
                end
                if (dly == 0) begin
                    MEM_ACK = 1'b1;
                    if (MEM_WE) begin
                        ram[int'(MEM_ADDR)] = MEM_WDATA;
                        MEM_RDATA = 16'($urandom);
                    end else
                        MEM_RDATA = ram.exists(int'(MEM_ADDR)) ? ram[int'(MEM_ADDR)] : init_word(MEM_ADDR);
                    active = 0;
                end else dly--;
            end else if (!MEM_REQ) active = 0;
        end
    end

    // monitor: memory requests, probes and INT pulse lengths
    initial begin
        logic        req_q = 0, int_low = 0;
        logic [31:0] cap = '0;
        int          ticks = 0;
        mreq_t       m;
        probe_t      p;
        forever begin
            @(posedge CLK); #1;
            if (RST) begin
                req_q = 0; int_low = 0;
            end else begin
                if (MEM_REQ && !req_q) begin
                    if (mem_exp.size() == 0) chk("mem_unexpected_req", 1, 0);
                    else begin
                        m = mem_exp.pop_front();
                        chk("mem_we", MEM_WE, m.we);
                        chk("mem_addr", MEM_ADDR, m.addr);
                        if (m.we) chk("mem_wdata", MEM_WDATA, m.wdata);
                    end
                    cap = {MEM_WE, MEM_ADDR, MEM_WDATA};
                end else if (MEM_REQ) begin
                    chk("mem_stable", {MEM_WE, MEM_ADDR, MEM_WDATA}, cap);
                    chk("wait_during_req", DSP_WAIT, 1);
                end
                req_q = MEM_REQ;

                if (probe_q.size() > 0) begin
                    p = probe_q[0];
                    if (!(p.kind == K_DI && DSP_WAIT)) begin
                        void'(probe_q.pop_front());
                        case (p.kind)
                            K_DI:    chk("dsp_di", DSP_DI, p.exp);
                            K_CTRL:  chk("ctrl_pins_rs_bio", {DSP_RS_N, DSP_BIO_N}, p.exp);
                            K_DONE:  chk("host_done", HOST_DONE, p.exp);
                            K_REQ:   chk("mem_req", MEM_REQ, p.exp);
                            K_INT:   chk("int_n", DSP_INT_N, p.exp);
                            default: chk("dsp_wait", DSP_WAIT, p.exp);
                        endcase
                    end
                end

                if (int_low) begin
                    if (CE_R && !(HOST_CTRL_WR && HOST_CTRL_D[2])) ticks++;
                    if (DSP_INT_N) begin
                        if (int_exp.size() == 0) chk("int_unexpected_pulse", 1, 0);
                        else chk("int_pulse_ticks", ticks, int_exp.pop_front());
                    end
                end else if (!DSP_INT_N) ticks = 0;
                int_low = !DSP_INT_N;
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        CE_R = ce_all ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic push(input int k, input logic [15:0] e);
        probe_t p;
        p.kind = k; p.exp = e;
        probe_q.push_back(p);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && probe_q.size() > 0; i++) step();
        if (probe_q.size() > 0) begin
            chk("probe_timeout", probe_q.size(), 0);
            probe_q.delete();
        end
    endtask

    task automatic wait_idle();
        step();
        for (int i = 0; i < 300 && DSP_WAIT; i++) step();
        if (DSP_WAIT) chk("idle_timeout", 1, 0);
    endtask

    task automatic dsp_wr(input logic [2:0] p, input logic [15:0] d);
        mreq_t m;
        wait_idle();
        DSP_A = p; DSP_DO = d; DSP_WE_N = 1'b0; CE_R = 1'b1;
        case (p)
            3'd0: addr_m = d[14:0];
            3'd1: begin
                m.we = 1; m.addr = addr_m; m.wdata = d;
                mem_exp.push_back(m);
                ram_m[int'(addr_m)] = d;
                addr_m = addr_m + 15'd1;
            end
            3'd3: done_m = d[15];
            default: ;
        endcase
        step();
        DSP_WE_N = 1'b1;
    endtask

    task automatic dsp_rd(input logic [2:0] p);
        mreq_t m;
        logic [15:0] e;
        wait_idle();
        DSP_A = p; DSP_DEN_N = 1'b0; CE_R = 1'b1;
        case (p)
            3'd0: e = {1'b0, addr_m};
            3'd1: begin
                m.we = 0; m.addr = addr_m; m.wdata = '0;
                mem_exp.push_back(m);
                rdata_m = ram_m.exists(int'(addr_m)) ? ram_m[int'(addr_m)] : init_word(addr_m);
                addr_m = addr_m + 15'd1;
                e = rdata_m;
            end
            3'd2: e = {15'b0, done_m};
            default: e = '0;
        endcase
        push(K_DI, e);
        step();
        DSP_DEN_N = 1'b1;
        drain();
    endtask

    task automatic peek(input logic [2:0] p, input logic [15:0] e);
        step();
        DSP_A = p;
        push(K_DI, e);
        drain();
    endtask

    task automatic host_ctrl(input logic [2:0] d);
        step();
        HOST_CTRL_WR = 1'b1; HOST_CTRL_D = d;
        bio_m = d[1];
        push(K_CTRL, {14'b0, d[0], ~d[1]});
        step();
        HOST_CTRL_WR = 1'b0;
        drain();
    endtask

    initial begin
        #500000;
        chk("watchdog", 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        mreq_t m;
        RST = 1'b1; CE_R = 1'b0; DSP_A = '0; DSP_DO = '0;
        DSP_WE_N = 1'b1; DSP_DEN_N = 1'b1; HOST_CTRL_WR = 1'b0; HOST_CTRL_D = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // reset state
        push(K_CTRL, 16'h1); push(K_REQ, 0); push(K_INT, 1); push(K_WAIT, 0);
        push(K_DONE, 0); push(K_DI, 0);
        drain();
        peek(3'd1, 16'h0);
        host_ctrl(3'b011);

        // address register round trip
        dsp_wr(3'd0, 16'h1234);
        dsp_rd(3'd0);

        // write at top of address space with delayed ack, then wrap
        dsp_wr(3'd0, 16'h7FFF);
        force_dly = 3;
        dsp_wr(3'd1, 16'hBEEF);
        dsp_rd(3'd0);

        // read with ack in the first request cycle
        dsp_wr(3'd0, 16'h0100);
        force_dly = -1;
        dsp_wr(3'd1, 16'hA55A);
        dsp_wr(3'd0, 16'h0100);
        force_dly = 0;
        dsp_rd(3'd1);
        dsp_rd(3'd0);
        force_dly = -1;

        // completion flag
        dsp_wr(3'd3, 16'h8000);
        dsp_rd(3'd2);
        dsp_wr(3'd3, 16'h0000);
        push(K_DONE, 0); drain();

        // host write and DSP port-3 write in the same cycle
        wait_idle();
        DSP_A = 3'd3; DSP_DO = 16'h8000; DSP_WE_N = 1'b0; CE_R = 1'b1;
        HOST_CTRL_WR = 1'b1; HOST_CTRL_D = 3'b001; bio_m = 1'b0;
        done_m = 1'b1;
        push(K_CTRL, 16'h3); push(K_DONE, 1);
        step();
        DSP_WE_N = 1'b1; HOST_CTRL_WR = 1'b0;
        drain();

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0: dsp_wr(3'd0, 16'($urandom));
                1, 2: dsp_wr(3'd1, 16'($urandom));
                3, 4: dsp_rd(3'd1);
                5: dsp_rd(3'd0);
                6: dsp_rd(3'd2);
                7: dsp_wr(3'd3, 16'($urandom));
                8: if ($urandom_range(0, 1) == 1) dsp_rd(3'($urandom_range(3, 7)));
                   else dsp_wr(3'($urandom_range(4, 7)), 16'($urandom));
                default: host_ctrl({1'b0, 1'($urandom_range(0, 1)), 1'b1});
            endcase
        end

        // host abort of an outstanding read, then a stray ack
        dsp_wr(3'd3, 16'h8000);
        hold_ack = 1'b1;
        wait_idle();
        DSP_A = 3'd1; DSP_DEN_N = 1'b0; CE_R = 1'b1;
        m.we = 0; m.addr = addr_m; m.wdata = '0;
        mem_exp.push_back(m);
        push(K_DI, rdata_m);
        step();
        DSP_DEN_N = 1'b1;
        repeat (4) step();
        host_ctrl({1'b0, bio_m, 1'b0});
        done_m = 1'b0;
        push(K_DONE, 0); push(K_REQ, 0); push(K_WAIT, 0);
        drain();
        peek(3'd0, {1'b0, addr_m});
        stray_cnt++;
        repeat (3) step();
        peek(3'd0, {1'b0, addr_m});
        peek(3'd1, rdata_m);
        push(K_REQ, 0); drain();
        hold_ack = 1'b0;
        host_ctrl({1'b0, bio_m, 1'b1});

        // INT pulse: single, then retrigger after two ticks
        int_exp.push_back(4);
        step();
        HOST_CTRL_WR = 1'b1; HOST_CTRL_D = {1'b1, bio_m, 1'b1};
        step();
        HOST_CTRL_WR = 1'b0;
        repeat (40) step();
        ce_all = 1'b1;
        int_exp.push_back(6);
        step();
        HOST_CTRL_WR = 1'b1;
        step();
        HOST_CTRL_WR = 1'b0;
        step();
        step();
        HOST_CTRL_WR = 1'b1;
        step();
        HOST_CTRL_WR = 1'b0;
        repeat (12) step();
        ce_all = 1'b0;
        chk("int_pulses_pending", int_exp.size(), 0);

        // asynchronous reset in the middle of a write
        hold_ack = 1'b1;
        wait_idle();
        DSP_A = 3'd1; DSP_DO = 16'h5AA5; DSP_WE_N = 1'b0; CE_R = 1'b1;
        m.we = 1; m.addr = addr_m; m.wdata = 16'h5AA5;
        mem_exp.push_back(m);
        step();
        DSP_WE_N = 1'b1;
        repeat (3) step();
        #2 RST = 1'b1;
        #1;
        chk("rst_mem_req", MEM_REQ, 0);
        chk("rst_mem_addr", MEM_ADDR, 0);
        chk("rst_wait", DSP_WAIT, 0);
        chk("rst_rs_n", DSP_RS_N, 0);
        chk("rst_bio_n", DSP_BIO_N, 1);
        chk("rst_di", DSP_DI, 0);
        step();
        RST = 1'b0;
        hold_ack = 1'b0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tms320_host_port_bridge.md
Name: tms320_host_port_bridge

Overview:
- Responder for the TMS320C1x DSP external port bus. It decodes the DSP's IN/OUT strobes (port address, write strobe, data-enable strobe) and maps them onto host-side shared RAM through a req/ack memory interface.
- It stalls the DSP while a host memory access is outstanding.
- It also gives the host CPU control of the DSP's RS_N, BIO_N and INT_N pins.
- Position: between the DSP core and the 68000 shared-RAM arbiter in the MCU block.

Parameters:
- ADDR_W, 15, host shared-RAM word-address width.
- INT_LEN, 4, length of the DSP_INT_N low pulse, in CE_R ticks.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- CE_R  in  1  DSP rising-phase clock enable; all DSP-side sampling happens on CLK edges where CE_R=1
- DSP_A  in  3  DSP port number, A[2:0]
- DSP_DO  in  16  DSP output data
- DSP_WE_N  in  1  DSP port-write strobe, active low
- DSP_DEN_N  in  1  DSP port-read strobe, active low
- DSP_DI  out  16  read data to the DSP
- DSP_WAIT  out  1  stall request; top level drives core EN = ~DSP_WAIT
- DSP_RS_N  out  1  DSP reset
- DSP_BIO_N  out  1  DSP BIO input
- DSP_INT_N  out  1  DSP interrupt
- HOST_CTRL_WR  in  1  one-cycle host write strobe to the control register
- HOST_CTRL_D  in  3  bit0 RUN, bit1 BIO, bit2 INT trigger
- HOST_DONE  out  1  DSP-written completion flag
- MEM_REQ  out  1  memory request, held until ack
- MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ
- MEM_ADDR  out  ADDR_W  word address
- MEM_WDATA  out  16  write data
- MEM_RDATA  in  16  read data, valid with MEM_ACK
- MEM_ACK  in  1  one-cycle acknowledge

Behaviour:
- Reset values:
  - DSP_DI=0, DSP_WAIT=0, DSP_RS_N=0 (DSP held in reset), DSP_BIO_N=1, DSP_INT_N=1.
  - HOST_DONE=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0.
  - ADDR register=0, RDATA latch=0, state=IDLE.
- Strobe detect: a write is DSP_WE_N=0, a read is DSP_DEN_N=0; each counts only on a CE_R=1 edge while DSP_WAIT=0.
- Port map, writes:
  - Port 0: ADDR <= DSP_DO[ADDR_W-1:0].
  - Port 1: host write.
  - Port 3: HOST_DONE <= DSP_DO[15].
  - Other ports: ignored.
- Port map, reads (DSP_DI is combinational from DSP_A):
  - Port 0: zero-extended ADDR.
  - Port 1: RDATA latch.
  - Port 2: {15'b0, HOST_DONE}.
  - Other ports: 0.
- DSP_WAIT = (state != IDLE) OR (CE_R AND port-1 strobe detected in IDLE). The DSP freezes in the same cycle the access is seen.
- FSM states: IDLE, RD, WR, FIN.
  - IDLE, port-1 read detected -> RD: MEM_REQ=1, MEM_WE=0, MEM_ADDR=ADDR.
  - IDLE, port-1 write detected -> WR: MEM_REQ=1, MEM_WE=1, MEM_WDATA=DSP_DO, MEM_ADDR=ADDR.
  - RD/WR, MEM_ACK=1 -> FIN: MEM_REQ=0; on a read, RDATA <= MEM_RDATA; ADDR <= ADDR+1, wrapping modulo 2^ADDR_W.
  - FIN -> IDLE on the next CE_R edge; DSP_WAIT drops, so the DSP resumes with RDATA already on DSP_DI.
  - Minimum stall: 2 CE_R-qualified cycles plus memory latency.
- MEM_ACK received in IDLE or FIN is ignored.
- MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA stay stable from request until ack.
- Control register, on HOST_CTRL_WR:
  - DSP_RS_N <= D[0].
  - DSP_BIO_N <= ~D[1].
  - D[2]=1 starts the INT pulse: DSP_INT_N=0 for INT_LEN CE_R ticks, then 1. A retrigger during a pulse reloads the counter.
- Host writes RUN=0 while an access is in RD/WR: the transaction aborts.
  - State -> IDLE, MEM_REQ -> 0 in the next cycle; ADDR and RDATA are unchanged.
  - HOST_DONE clears.
- Host write and DSP port-3 write in the same cycle: both update their own fields; there is no conflict.
- An asynchronous RST mid-transaction returns every output to its reset value immediately.

Test Plan:
- After RST deassert:
  - Outputs read RS_N=0, BIO_N=1, INT_N=1, MEM_REQ=0.
  - HOST_CTRL_WR with D=3'b011 -> RS_N=1, BIO_N=0 on the next cycle.
- DSP writes 0x1234 to port 0, then reads port 0 -> DSP_DI=0x1234 (ADDR_W=15).
- Port-1 write of 0xBEEF at ADDR=0x7FFF, MEM_ACK delayed 3 cycles:
  - DSP_WAIT high from the detect cycle until FIN->IDLE.
  - MEM_WE=1, MEM_ADDR=0x7FFF, MEM_WDATA=0xBEEF held stable throughout.
  - ADDR wraps to 0x0000 afterwards.
- Port-1 read with MEM_RDATA=0xA55A, ack in the first request cycle:
  - DSP_DI=0xA55A when DSP_WAIT drops.
  - Port-0 read then returns ADDR+1.
- Port-3 write 0x8000 -> HOST_DONE=1 and a port-2 read returns 0x0001. Port-3 write 0x0000 -> HOST_DONE=0.
- Host RUN=0 while in RD with no ack:
  - MEM_REQ falls, state returns to IDLE, DSP_WAIT=0, ADDR unchanged.
  - A stray MEM_ACK afterwards causes no change.
- INT pulse:
  - D[2]=1 -> DSP_INT_N low for exactly 4 CE_R ticks.
  - A retrigger at tick 2 extends the pulse to 6 ticks total.
